// File: rtl/prm_iss_que.sv
// prm_iss_que: unified issue queue with wakeup tracking, age-matrix
// oldest-ready pick per function unit, and branch-mask flush/commit.

// Per-unit oldest-candidate picker over the age matrix.
module prm_iss_que_pick #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            pick,
  output logic                        found
);
  // An entry wins when no other candidate is older than it.
  always_comb begin
    pick = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pick[i] = cand[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && age[j][i]) pick[i] = 1'b0;
    end
  end

  assign found = |cand;
endmodule

module prm_iss_que #(
  parameter int DEPTH    = 16,
  parameter int IN_PORTS = 4,
  parameter int FU_NUM   = 4,
  parameter int FU_BITS  = 2,
  parameter int WK_PORTS = 4,
  parameter int PRG_BITS = 6,
  parameter int BRN_NUM  = 4,
  parameter int PAY_W    = 32,
  localparam int ENT_W   = PAY_W + BRN_NUM + 3*PRG_BITS + 2 + FU_BITS,
  localparam int BID_W   = $clog2(BRN_NUM),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_PORTS-1:0]                alc_vld,
  input  logic [IN_PORTS-1:0][ENT_W-1:0]     alc_ins,
  output logic                               ful_to_al,
  input  logic [WK_PORTS-1:0]                wk_vld,
  input  logic [WK_PORTS-1:0][PRG_BITS-1:0]  wk_prg,
  input  logic [FU_NUM-1:0]                  fu_rdy,
  input  logic                               fls_vld,
  input  logic [BID_W-1:0]                   fls_id,
  input  logic                               cmt_vld,
  input  logic [BID_W-1:0]                   cmt_id,
  output logic [FU_NUM-1:0]                  iss_vld,
  output logic [FU_NUM-1:0][ENT_W-1:0]       iss_ins,
  output logic [CNT_W-1:0]                   fre_cnt
);

  typedef struct packed {
    logic [PAY_W-1:0]    pay;
    logic [BRN_NUM-1:0]  msk;
    logic                s1v;
    logic [PRG_BITS-1:0] ps1;
    logic                s2v;
    logic [PRG_BITS-1:0] ps2;
    logic [PRG_BITS-1:0] pdst;
    logic [FU_BITS-1:0]  fu;
  } ent_t;

  function automatic logic wk_hit(
    input logic [PRG_BITS-1:0]               r,
    input logic [WK_PORTS-1:0]               v,
    input logic [WK_PORTS-1:0][PRG_BITS-1:0] g
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < WK_PORTS; k++)
      if (v[k] && g[k] == r) h = 1'b1;
    return h;
  endfunction

  // entry state
  ent_t [DEPTH-1:0]            ent_q;
  logic [DEPTH-1:0]            vld_q, r1_q, r2_q;
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  // allocation
  ent_t [IN_PORTS-1:0]            ain;
  logic [IN_PORTS-1:0]            aok;
  logic [IN_PORTS-1:0][DEPTH-1:0] aoh;
  logic [DEPTH-1:0]               alc_any;

  // select / flush
  logic [DEPTH-1:0]              kill, iss_oh;
  logic [FU_NUM-1:0][DEPTH-1:0]  cand, pick;
  logic [FU_NUM-1:0]             pk_fnd;
  ent_t [FU_NUM-1:0]             iss_d;
  logic [CNT_W-1:0]              n_alc, n_iss, n_kil, fre_d;

  assign ful_to_al = (fre_cnt < CNT_W'(IN_PORTS));

  // Incoming group: apply commit to masks; drop whole group when full,
  // and drop ports whose original mask hits the flushed branch.
  always_comb begin
    ain = '0;
    aok = '0;
    for (int p = 0; p < IN_PORTS; p++) begin
      ain[p] = ent_t'(alc_ins[p]);
      aok[p] = alc_vld[p] && !ful_to_al && !(fls_vld && ain[p].msk[fls_id]);
      if (cmt_vld) ain[p].msk[cmt_id] = 1'b0;
    end
  end

  // Steer accepted ports to free entries, lowest index first, in port order.
  always_comb begin
    logic [DEPTH-1:0] fre_m;
    logic             fnd;
    fre_m   = ~vld_q;
    aoh     = '0;
    fnd     = 1'b0;
    for (int p = 0; p < IN_PORTS; p++) begin
      fnd = 1'b0;
      if (aok[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!fnd && fre_m[i]) begin
            aoh[p][i] = 1'b1;
            fre_m[i]  = 1'b0;
            fnd       = 1'b1;
          end
        end
      end
    end
    alc_any = '0;
    for (int p = 0; p < IN_PORTS; p++) alc_any = alc_any | aoh[p];
  end

  // Age update: a new entry is younger than everything valid and than
  // lower-numbered ports allocating in the same cycle.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alc_any[i]) begin
        age_d[i] = '0;
        for (int j = 0; j < DEPTH; j++)
          if (vld_q[j]) age_d[j][i] = 1'b1;
      end
    end
    for (int p = 0; p < IN_PORTS; p++)
      for (int q = p + 1; q < IN_PORTS; q++)
        for (int i = 0; i < DEPTH; i++)
          for (int k = 0; k < DEPTH; k++)
            if (aoh[p][i] && aoh[q][k]) age_d[i][k] = 1'b1;
  end

  // Kill and candidate vectors; killed entries never compete.
  always_comb begin
    kill = '0;
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = vld_q[i] && fls_vld && ent_q[i].msk[fls_id];
      for (int f = 0; f < FU_NUM; f++)
        cand[f][i] = vld_q[i] && r1_q[i] && r2_q[i] && !kill[i] &&
                     (ent_q[i].fu == FU_BITS'(f)) && fu_rdy[f];
    end
  end

  for (genvar f = 0; f < FU_NUM; f++) begin : g_pick
    prm_iss_que_pick #(.DEPTH(DEPTH)) u_pick (
      .cand  (cand[f]),
      .age   (age_q),
      .pick  (pick[f]),
      .found (pk_fnd[f])
    );
  end

  // One-hot mux of the winning entry per unit, plus the freed-entry set.
  always_comb begin
    iss_d  = '0;
    iss_oh = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      iss_oh = iss_oh | pick[f];
      for (int i = 0; i < DEPTH; i++)
        if (pick[f][i]) iss_d[f] = ent_q[i];
    end
  end

  // Free count bookkeeping.
  always_comb begin
    n_alc = CNT_W'($countones(aok));
    n_iss = CNT_W'($countones(iss_oh));
    n_kil = CNT_W'($countones(kill));
    fre_d = fre_cnt - n_alc + n_iss + n_kil;
  end

  // Entry storage: free on issue/kill, wake and commit held entries, then
  // write new allocations (ready if no source or woken this same cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      ent_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i] || iss_oh[i]) begin
          vld_q[i] <= 1'b0;
        end else if (vld_q[i]) begin
          if (wk_hit(ent_q[i].ps1, wk_vld, wk_prg)) r1_q[i] <= 1'b1;
          if (wk_hit(ent_q[i].ps2, wk_vld, wk_prg)) r2_q[i] <= 1'b1;
          if (cmt_vld) ent_q[i].msk[cmt_id] <= 1'b0;
        end
      end
      for (int p = 0; p < IN_PORTS; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (aoh[p][i]) begin
            vld_q[i] <= 1'b1;
            ent_q[i] <= ain[p];
            r1_q[i]  <= !ain[p].s1v || wk_hit(ain[p].ps1, wk_vld, wk_prg);
            r2_q[i]  <= !ain[p].s2v || wk_hit(ain[p].ps2, wk_vld, wk_prg);
          end
        end
      end
    end
  end

  // Age matrix and free count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q   <= '0;
      fre_cnt <= CNT_W'(DEPTH);
    end else begin
      age_q   <= age_d;
      fre_cnt <= fre_d;
    end
  end

  // Registered issue ports; payload holds when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld <= '0;
      iss_ins <= '0;
    end else begin
      iss_vld <= pk_fnd;
      for (int f = 0; f < FU_NUM; f++)
        if (pk_fnd[f]) iss_ins[f] <= iss_d[f];
    end
  end

endmodule

// File: tb/tb_prm_iss_que.sv
// Directed scoreboard bench for prm_iss_que: stimulus pushes expected
// (edge, entry) per unit; a negedge monitor pops on every issue.
module tb_prm_iss_que;
  localparam int DEPTH = 16, IN_PORTS = 4, FU_NUM = 4, FU_BITS = 2;
  localparam int WK_PORTS = 4, PRG_BITS = 6, BRN_NUM = 4, PAY_W = 32;
  localparam int ENT_W = PAY_W + BRN_NUM + 3*PRG_BITS + 2 + FU_BITS;
  localparam int BID_W = 2, CNT_W = 5;

  logic                              clk = 1'b0;
  logic                              rst;
  logic [IN_PORTS-1:0]               alc_vld;
  logic [IN_PORTS-1:0][ENT_W-1:0]    alc_ins;
  logic                              ful_to_al;
  logic [WK_PORTS-1:0]               wk_vld;
  logic [WK_PORTS-1:0][PRG_BITS-1:0] wk_prg;
  logic [FU_NUM-1:0]                 fu_rdy;
  logic                              fls_vld;
  logic [BID_W-1:0]                  fls_id;
  logic                              cmt_vld;
  logic [BID_W-1:0]                  cmt_id;
  logic [FU_NUM-1:0]                 iss_vld;
  logic [FU_NUM-1:0][ENT_W-1:0]      iss_ins;
  logic [CNT_W-1:0]                  fre_cnt;

  prm_iss_que dut (
    .clk(clk), .rst(rst), .alc_vld(alc_vld), .alc_ins(alc_ins),
    .ful_to_al(ful_to_al), .wk_vld(wk_vld), .wk_prg(wk_prg),
    .fu_rdy(fu_rdy), .fls_vld(fls_vld), .fls_id(fls_id),
    .cmt_vld(cmt_vld), .cmt_id(cmt_id), .iss_vld(iss_vld),
    .iss_ins(iss_ins), .fre_cnt(fre_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [ENT_W-1:0] ins; } exp_t;
  exp_t q0[$], q1[$], q2[$], q3[$];
  int checks = 0, errors = 0;

  function automatic logic [ENT_W-1:0] mk(input int pd, input logic [3:0] msk,
      input logic s1v, input int ps1, input int fu);
    logic [PAY_W-1:0] pay;
    pay = 32'hA500_0000 + 32'(pd);
    return {pay, msk, s1v, PRG_BITS'(ps1), 1'b0, PRG_BITS'(0), PRG_BITS'(pd), FU_BITS'(fu)};
  endfunction

  task automatic push(input int f, input int c, input logic [ENT_W-1:0] w);
    exp_t e;
    e.cyc = c; e.ins = w;
    case (f)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_iss(input int f);
    exp_t e;
    logic got;
    got = 1'b0;
    case (f)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
    endcase
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL iss_unexpected fu%0d: got ins %h at cyc %0d, expected no issue",
               f, iss_ins[f], cyc);
    end else if (e.cyc != cyc || e.ins !== iss_ins[f]) begin
      errors++;
      $display("FAIL iss fu%0d: got ins %h at cyc %0d, expected ins %h at cyc %0d",
               f, iss_ins[f], cyc, e.ins, e.cyc);
    end
  endtask

  // Monitor: every asserted issue port must match the head of its queue.
  always @(negedge clk)
    for (int f = 0; f < FU_NUM; f++)
      if (iss_vld[f] === 1'b1) chk_iss(f);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alc_vld = '0; wk_vld = '0; fls_vld = 1'b0; cmt_vld = 1'b0;
  endtask

  logic [ENT_W-1:0] wds[16];
  logic [ENT_W-1:0] w, wa, wb;

  initial begin
    rst = 1'b1; alc_vld = '0; alc_ins = '0; wk_vld = '0; wk_prg = '0;
    fu_rdy = '1; fls_vld = 1'b0; fls_id = '0; cmt_vld = 1'b0; cmt_id = '0;
    tick(); tick();
    chk("rst_iss_vld", 64'(iss_vld), 64'd0);
    chk("rst_iss_ins", 64'(|iss_ins), 64'd0);
    chk("rst_fre_cnt", 64'(fre_cnt), 64'd16);
    chk("rst_ful", 64'(ful_to_al), 64'd0);
    rst = 1'b0;
    tick();

    // 1: four ready instructions, one per unit, issue on the next edge
    for (int f = 0; f < 4; f++) begin
      w = mk(f + 1, 4'b0000, 1'b0, 0, f);
      alc_vld[f] = 1'b1; alc_ins[f] = w;
      push(f, cyc + 2, w);
    end
    tick(); idle();
    chk("t1_fre_alloc", 64'(fre_cnt), 64'd12);
    tick();
    chk("t1_iss_vld", 64'(iss_vld), 64'hF);
    chk("t1_fre_back", 64'(fre_cnt), 64'd16);

    // 2: fill all 16 entries waiting on p5, drop a 5th group, then wake
    for (int g = 0; g < 4; g++) begin
      chk("t2_ful_fill", 64'(ful_to_al), 64'd0);
      for (int f = 0; f < 4; f++) begin
        wds[4*g+f] = mk(8 + 4*g + f, 4'b0000, 1'b1, 5, f);
        alc_vld[f] = 1'b1; alc_ins[f] = wds[4*g+f];
      end
      tick(); idle();
    end
    chk("t2_fre_zero", 64'(fre_cnt), 64'd0);
    chk("t2_ful_set", 64'(ful_to_al), 64'd1);
    for (int f = 0; f < 4; f++) begin
      alc_vld[f] = 1'b1; alc_ins[f] = mk(30 + f, 4'b0000, 1'b1, 5, f);
    end
    tick(); idle();
    chk("t2_drop_fre", 64'(fre_cnt), 64'd0);
    wk_vld[0] = 1'b1; wk_prg[0] = 6'd5;
    for (int g = 0; g < 4; g++)
      for (int f = 0; f < 4; f++) push(f, cyc + 2 + g, wds[4*g+f]);
    tick(); idle();
    repeat (5) tick();
    chk("t2_fre_drain", 64'(fre_cnt), 64'd16);

    // 3: older A sits above younger B in index order; age decides
    alc_vld = 4'b0011;
    alc_ins[0] = mk(40, 4'b0000, 1'b1, 20, 0);
    wa = mk(41, 4'b0000, 1'b1, 9, 1);
    alc_ins[1] = wa;
    tick(); idle();
    wk_vld[0] = 1'b1; wk_prg[0] = 6'd20;
    push(0, cyc + 2, mk(40, 4'b0000, 1'b1, 20, 0));
    tick(); idle();
    tick();
    wb = mk(42, 4'b0000, 1'b1, 9, 1);
    alc_vld[0] = 1'b1; alc_ins[0] = wb;
    tick(); idle();
    wk_vld[1] = 1'b1; wk_prg[1] = 6'd9;
    push(1, cyc + 2, wa);
    push(1, cyc + 3, wb);
    tick(); idle();
    repeat (4) tick();
    chk("t3_fre", 64'(fre_cnt), 64'd16);

    // 4: flush branch 1 kills a waiting and a ready entry plus an incoming one
    alc_vld = 4'b0111;
    alc_ins[0] = mk(50, 4'b0010, 1'b1, 11, 2);
    w = mk(51, 4'b0001, 1'b1, 11, 2);
    alc_ins[1] = w;
    alc_ins[2] = mk(52, 4'b0010, 1'b0, 0, 3);
    tick(); idle();
    chk("t4_fre_alloc", 64'(fre_cnt), 64'd13);
    fls_vld = 1'b1; fls_id = 2'd1;
    alc_vld[0] = 1'b1; alc_ins[0] = mk(53, 4'b0010, 1'b0, 0, 0);
    tick(); idle();
    chk("t4_fre_flush", 64'(fre_cnt), 64'd15);
    wk_vld[2] = 1'b1; wk_prg[2] = 6'd11;
    push(2, cyc + 2, w);
    tick(); idle();
    repeat (3) tick();
    chk("t4_fre_end", 64'(fre_cnt), 64'd16);

    // 5: commit branch 0 (held and incoming), later flush 0 kills nothing
    alc_vld[0] = 1'b1; alc_ins[0] = mk(60, 4'b0001, 1'b1, 12, 0);
    tick(); idle();
    cmt_vld = 1'b1; cmt_id = 2'd0;
    alc_vld[0] = 1'b1; alc_ins[0] = mk(61, 4'b0001, 1'b1, 12, 0);
    tick(); idle();
    chk("t5_fre_cmt", 64'(fre_cnt), 64'd14);
    fls_vld = 1'b1; fls_id = 2'd0;
    tick(); idle();
    chk("t5_fre_nokill", 64'(fre_cnt), 64'd14);
    wk_vld[3] = 1'b1; wk_prg[3] = 6'd12;
    push(0, cyc + 2, mk(60, 4'b0000, 1'b1, 12, 0));
    push(0, cyc + 3, mk(61, 4'b0000, 1'b1, 12, 0));
    tick(); idle();
    repeat (4) tick();
    chk("t5_fre_end", 64'(fre_cnt), 64'd16);

    // 6: unit 2 back-pressured, then released; then reset mid-stream
    fu_rdy = 4'b1011;
    w = mk(70, 4'b0000, 1'b0, 0, 2);
    alc_vld[0] = 1'b1; alc_ins[0] = w;
    tick(); idle();
    repeat (3) tick();
    chk("t6_hold_vld", 64'(iss_vld), 64'd0);
    chk("t6_hold_fre", 64'(fre_cnt), 64'd15);
    fu_rdy = 4'b1111;
    push(2, cyc + 1, w);
    tick();
    tick();
    fu_rdy = 4'b0000;
    for (int f = 0; f < 4; f++) begin
      alc_vld[f] = 1'b1; alc_ins[f] = mk(80 + f, 4'b0000, 1'b0, 0, f);
    end
    tick(); idle();
    chk("t6_pre_rst_fre", 64'(fre_cnt), 64'd12);
    rst = 1'b1; fu_rdy = 4'b1111;
    tick();
    chk("t6_rst_vld", 64'(iss_vld), 64'd0);
    chk("t6_rst_ins", 64'(|iss_ins), 64'd0);
    chk("t6_rst_fre", 64'(fre_cnt), 64'd16);
    chk("t6_rst_ful", 64'(ful_to_al), 64'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_post_fre", 64'(fre_cnt), 64'd16);

    chk("sb_empty", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
